// File: rtl/wm_phase_timer.sv
// Washer phase timer: times fill/heat/wash/rinse/spin against per-phase tick budgets.
// Optional over-stay watchdog enabled by defining WM_TIMER_TIMEOUT_EN.
module wm_phase_timer #(
    parameter int CNT_W          = 8,
    parameter int TICK_DIV       = 1,
    parameter int FILL_TIME      = 2,
    parameter int HEAT_TIME      = 3,
    parameter int WASH_TIME      = 5,
    parameter int RINSE_TIME     = 3,
    parameter int SPIN_TIME      = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [2:0]       state,
    input  logic             pause,
    output logic             sig_Full,
    output logic             sig_Temperature,
    output logic             sig_Wash_Completed,
    output logic             sig_Rinse_Completed,
    output logic             sig_Spin_Completed,
    output logic             phase_done,
    output logic [CNT_W-1:0] remaining,
    output logic             sig_Timeout
);

    localparam int PRESC_W = 16;
    localparam int MAX_T   = (2 ** CNT_W) - 1;

    localparam logic [2:0] ST_START  = 3'd0;
    localparam logic [2:0] ST_READY  = 3'd1;
    localparam logic [2:0] ST_FILL   = 3'd2;
    localparam logic [2:0] ST_HEAT   = 3'd3;
    localparam logic [2:0] ST_WASH   = 3'd4;
    localparam logic [2:0] ST_RINSE  = 3'd5;
    localparam logic [2:0] ST_SPIN   = 3'd6;
    localparam logic [2:0] ST_UNUSED = 3'd7;

    if (FILL_TIME < 1 || FILL_TIME > MAX_T || HEAT_TIME < 1 || HEAT_TIME > MAX_T ||
        WASH_TIME < 1 || WASH_TIME > MAX_T || RINSE_TIME < 1 || RINSE_TIME > MAX_T ||
        SPIN_TIME < 1 || SPIN_TIME > MAX_T || TICK_DIV < 1 || TICK_DIV > 65536 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("wm_phase_timer: parameter out of range");
    end

    logic [2:0]         prev_state_r;
    logic [CNT_W-1:0]   count_r;
    logic [PRESC_W-1:0] presc_r;
    logic [4:0]         flags_r;
    logic               phase_done_r;

    logic               is_timed_s;
    logic [CNT_W-1:0]   cur_time_s;
    logic [4:0]         flag_mask_s;
    logic               cur_flag_s;
    logic               presc_wrap_s;
    logic [CNT_W-1:0]   count_next_s;

    // Decode the current phase into its budget and flag position
    always_comb begin
        is_timed_s  = 1'b1;
        cur_time_s  = '0;
        flag_mask_s = 5'b00000;
        case (state)
            ST_FILL:  begin cur_time_s = CNT_W'(FILL_TIME);  flag_mask_s = 5'b00001; end
            ST_HEAT:  begin cur_time_s = CNT_W'(HEAT_TIME);  flag_mask_s = 5'b00010; end
            ST_WASH:  begin cur_time_s = CNT_W'(WASH_TIME);  flag_mask_s = 5'b00100; end
            ST_RINSE: begin cur_time_s = CNT_W'(RINSE_TIME); flag_mask_s = 5'b01000; end
            ST_SPIN:  begin cur_time_s = CNT_W'(SPIN_TIME);  flag_mask_s = 5'b10000; end
            default:  is_timed_s = 1'b0;
        endcase
        cur_flag_s   = |(flags_r & flag_mask_s);
        presc_wrap_s = (presc_r == PRESC_W'(TICK_DIV - 1));
        count_next_s = count_r + CNT_W'(1);
    end

    // Phase tracking, prescaler, tick counter and completion flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_state_r <= ST_START;
            count_r      <= '0;
            presc_r      <= '0;
            flags_r      <= 5'b00000;
            phase_done_r <= 1'b0;
        end else begin
            phase_done_r <= 1'b0;
            if (state == ST_UNUSED) begin
                prev_state_r <= prev_state_r;
            end else if (state == ST_START || state == ST_READY) begin
                prev_state_r <= state;
                count_r      <= '0;
                presc_r      <= '0;
                flags_r      <= 5'b00000;
            end else if (state != prev_state_r) begin
                prev_state_r <= state;
                count_r      <= '0;
                presc_r      <= '0;
            end else if (!cur_flag_s && !pause) begin
                if (presc_wrap_s) begin
                    presc_r <= '0;
                    count_r <= count_next_s;
                    if (count_next_s == cur_time_s) begin
                        flags_r      <= flags_r | flag_mask_s;
                        phase_done_r <= 1'b1;
                    end
                end else begin
                    presc_r <= presc_r + PRESC_W'(1);
                end
            end
        end
    end

    // Remaining ticks; guarded because count may still belong to the previous phase
    always_comb begin
        remaining = '0;
        if (is_timed_s && count_r <= cur_time_s) begin
            remaining = cur_time_s - count_r;
        end else begin
            remaining = '0;
        end
    end

    assign sig_Full            = flags_r[0];
    assign sig_Temperature     = flags_r[1];
    assign sig_Wash_Completed  = flags_r[2];
    assign sig_Rinse_Completed = flags_r[3];
    assign sig_Spin_Completed  = flags_r[4];
    assign phase_done          = phase_done_r;

`ifdef WM_TIMER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdog_r;
    logic            timeout_r;

    // Watchdog: counts clocks spent in a phase whose flag is already set
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wdog_r    <= '0;
            timeout_r <= 1'b0;
        end else if (state == ST_UNUSED) begin
            wdog_r <= wdog_r;
        end else if (state == ST_START || state == ST_READY) begin
            wdog_r    <= '0;
            timeout_r <= 1'b0;
        end else if (state != prev_state_r) begin
            wdog_r <= '0;
        end else if (cur_flag_s && wdog_r != WD_W'(TIMEOUT_CYCLES)) begin
            wdog_r <= wdog_r + WD_W'(1);
            if (wdog_r + WD_W'(1) == WD_W'(TIMEOUT_CYCLES)) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign sig_Timeout = timeout_r;
`else
    assign sig_Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wm_phase_timer.sv
// Directed bench for wm_phase_timer: one instance at TICK_DIV=1, one at TICK_DIV=4.
module tb_wm_phase_timer;

    logic       clock;
    logic       reset_n;
    logic [2:0] state;
    logic [2:0] state4;
    logic       pause;

    logic       full, temp, wash, rinse, spin, pdone, tmo;
    logic [7:0] rem;
    logic       full4, temp4, wash4, rinse4, spin4, pdone4, tmo4;
    logic [7:0] rem4;
    logic [4:0] flags;

    int checks = 0;
    int errors = 0;

`ifdef WM_TIMER_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    assign flags = {spin, rinse, wash, temp, full};

    wm_phase_timer dut (
        .clock(clock), .reset_n(reset_n), .state(state), .pause(pause),
        .sig_Full(full), .sig_Temperature(temp), .sig_Wash_Completed(wash),
        .sig_Rinse_Completed(rinse), .sig_Spin_Completed(spin),
        .phase_done(pdone), .remaining(rem), .sig_Timeout(tmo)
    );

    wm_phase_timer #(.TICK_DIV(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .state(state4), .pause(pause),
        .sig_Full(full4), .sig_Temperature(temp4), .sig_Wash_Completed(wash4),
        .sig_Rinse_Completed(rinse4), .sig_Spin_Completed(spin4),
        .phase_done(pdone4), .remaining(rem4), .sig_Timeout(tmo4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        state   = 3'd1;
        state4  = 3'd1;
        pause   = 1'b0;
        #1;
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_pdone", 32'(pdone), 32'd0);
        check("rst_tmo", 32'(tmo), 32'd0);
        step(1);
        reset_n = 1'b1;
        step(1);
        check("ready_flags", 32'(flags), 32'd0);
        check("ready_rem", 32'(rem), 32'd0);

        // FILL: flag after the 3rd edge, remaining 2,2,1,0
        state = 3'd2;
        #1;
        check("fill_rem0", 32'(rem), 32'd2);
        step(1);
        check("fill_e1_full", 32'(full), 32'd0);
        check("fill_e1_rem", 32'(rem), 32'd2);
        step(1);
        check("fill_e2_full", 32'(full), 32'd0);
        check("fill_e2_rem", 32'(rem), 32'd1);
        step(1);
        check("fill_e3_full", 32'(full), 32'd1);
        check("fill_e3_pdone", 32'(pdone), 32'd1);
        check("fill_e3_rem", 32'(rem), 32'd0);
        step(1);
        check("fill_e4_pdone", 32'(pdone), 32'd0);
        check("fill_e4_rem", 32'(rem), 32'd0);

        // HEAT: 4 edges
        state = 3'd3;
        step(3);
        check("heat_e3", 32'(temp), 32'd0);
        step(1);
        check("heat_e4", 32'(temp), 32'd1);

        // WASH with a 4-clock pause: 10 edges instead of 6
        state = 3'd4;
        step(3);
        check("wash_prepause_rem", 32'(rem), 32'd3);
        pause = 1'b1;
        step(4);
        check("wash_pause_rem", 32'(rem), 32'd3);
        check("wash_pause_flag", 32'(wash), 32'd0);
        pause = 1'b0;
        step(2);
        check("wash_e9", 32'(wash), 32'd0);
        step(1);
        check("wash_e10", 32'(wash), 32'd1);
        check("wash_e10_pdone", 32'(pdone), 32'd1);

        // RINSE and SPIN
        state = 3'd5;
        step(4);
        check("rinse_e4", 32'(rinse), 32'd1);
        state = 3'd6;
        step(3);
        check("spin_e3", 32'(spin), 32'd0);
        step(1);
        check("spin_e4", 32'(spin), 32'd1);
        check("all_flags", 32'(flags), 32'h1f);

        // Over-stay in SPIN
        step(15);
        check("tmo_15", 32'(tmo), 32'd0);
        step(1);
        check("tmo_16", 32'(tmo), 32'(TO_EN));
        step(5);
        check("tmo_sticky", 32'(tmo), 32'(TO_EN));

        // Re-enter completed WASH: count clears, flag stays, no new pulse
        state = 3'd4;
        step(1);
        check("reenter_rem", 32'(rem), 32'd5);
        check("reenter_flag", 32'(wash), 32'd1);
        step(6);
        check("reenter_hold_rem", 32'(rem), 32'd5);
        check("reenter_pdone", 32'(pdone), 32'd0);

        // Unused state holds everything
        state = 3'd7;
        step(3);
        check("st7_flags", 32'(flags), 32'h1f);
        check("st7_rem", 32'(rem), 32'd0);
        check("st7_tmo", 32'(tmo), 32'(TO_EN));

        // READY clears all
        state = 3'd1;
        step(1);
        check("clr_flags", 32'(flags), 32'd0);
        check("clr_tmo", 32'(tmo), 32'd0);

        // Async reset mid-RINSE at count=2, then a fresh 4 edges
        state = 3'd5;
        step(3);
        check("rinse_cnt2_rem", 32'(rem), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_rem", 32'(rem), 32'd3);
        check("arst_flags", 32'(flags), 32'd0);
        #3;
        reset_n = 1'b1;
        step(3);
        check("rst_rinse_e3", 32'(rinse), 32'd0);
        step(1);
        check("rst_rinse_e4", 32'(rinse), 32'd1);

        // TICK_DIV=4 HEAT: flag after 13 edges, remaining steps every 4 clocks
        state4 = 3'd3;
        step(4);
        check("div4_e4_rem", 32'(rem4), 32'd3);
        step(1);
        check("div4_e5_rem", 32'(rem4), 32'd2);
        step(7);
        check("div4_e12_rem", 32'(rem4), 32'd1);
        check("div4_e12_flag", 32'(temp4), 32'd0);
        step(1);
        check("div4_e13_flag", 32'(temp4), 32'd1);
        check("div4_e13_rem", 32'(rem4), 32'd0);
        check("div4_e13_pdone", 32'(pdone4), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
